// File: rtl/multiplier_control_taint_v2_if.sv
// Handshake/control bundle between the shift-add multiplier controller and
// its surroundings: start/taint-clear requests and the multiplier word come
// in, datapath strobes and their sticky taint bits go out.
interface multiplier_control_taint_v2_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             start_t;
    logic             taint_clr;
    logic [WIDTH-1:0] multiplierReg;
    logic             multiplierReg_t;

    logic             busy;
    logic             busy_t;
    logic             productDone;
    logic             productDone_t;
    logic             rsload;
    logic             rsload_t;
    logic             rsclear;
    logic             rsclear_t;
    logic             rsshr;
    logic             rsshr_t;
    logic             mrld;
    logic             mrld_t;
    logic             mdld;
    logic             mdld_t;

    // Requester side: drives start/taints/multiplier word, observes strobes.
    modport master (
        output start, start_t, taint_clr, multiplierReg, multiplierReg_t,
        input  busy, busy_t, productDone, productDone_t, rsload, rsload_t,
               rsclear, rsclear_t, rsshr, rsshr_t, mrld, mrld_t, mdld, mdld_t
    );

    // Controller side.
    modport slave (
        input  start, start_t, taint_clr, multiplierReg, multiplierReg_t,
        output busy, busy_t, productDone, productDone_t, rsload, rsload_t,
               rsclear, rsclear_t, rsshr, rsshr_t, mrld, mrld_t, mdld, mdld_t
    );
endinterface

// File: rtl/multiplier_control_taint_v2.sv
// Control FSM for a shift-add sequential multiplier with word-level sticky
// taint tracking on every control output.
// Optional feature macro: MULT_ZERO_SKIP_EN -- when defined, a zero
// multiplier bit skips the NOP state (data-dependent latency, which in turn
// taints the timing of every output).
module multiplier_control_taint_v2 #(
    parameter int WIDTH = 4
) (
    input logic                          clk,
    input logic                          rst,
    multiplier_control_taint_v2_if.slave ctl
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

`ifdef MULT_ZERO_SKIP_EN
    localparam bit ZERO_SKIP = 1'b1;
`else
    localparam bit ZERO_SKIP = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        LOAD  = 3'd2,
        NOP   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nx, cnt_inc;
    logic             time_t, sel_t, cnt_t;
    logic             time_t_nx, sel_t_nx, cnt_t_nx;
    logic             sel_bit;     // multiplier bit chosen at a decision edge
    logic             decide;      // current edge is an INIT/SHIFT decision edge
    logic             data_t;      // taint of the value steering the decision
    logic             clr;         // taint clear honoured this cycle

    // Next-state, bit counter and sticky-taint next values.
    // NOTE: every variable gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        cnt_inc    = bit_cnt + 1'b1;
        decide     = 1'b0;
        sel_bit    = 1'b0;

        case (state)
            IDLE: begin
                if (ctl.start) state_nx = INIT;
            end
            INIT: begin
                decide     = 1'b1;
                bit_cnt_nx = '0;
                sel_bit    = ctl.multiplierReg[0];
                state_nx   = sel_bit ? LOAD : (ZERO_SKIP ? SHIFT : NOP);
            end
            LOAD, NOP: begin
                state_nx = SHIFT;
            end
            SHIFT: begin
                decide     = 1'b1;
                bit_cnt_nx = cnt_inc;
                if (cnt_inc == CNT_W'(WIDTH)) begin
                    state_nx = DONE;
                end else begin
                    sel_bit  = |(ctl.multiplierReg & (WIDTH'(1) << cnt_inc));
                    state_nx = sel_bit ? LOAD : (ZERO_SKIP ? SHIFT : NOP);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Taint bits only ever set; the IDLE clear is applied first so a
        // same-cycle set event wins.
        data_t    = ctl.multiplierReg_t | cnt_t;
        clr       = (state == IDLE) && ctl.taint_clr;
        time_t_nx = (time_t & ~clr) | ((state == IDLE) && ctl.start_t)
                  | (ZERO_SKIP && decide && data_t);
        sel_t_nx  = (sel_t & ~clr) | (decide & data_t);
        cnt_t_nx  = (cnt_t & ~clr) | (decide & time_t);
    end

    // State, counter, taints and registered Moore outputs decoded from the
    // next state so every output lines up with the state it belongs to.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            bit_cnt           <= '0;
            time_t            <= 1'b0;
            sel_t             <= 1'b0;
            cnt_t             <= 1'b0;
            ctl.busy          <= 1'b0;
            ctl.productDone   <= 1'b0;
            ctl.rsload        <= 1'b0;
            ctl.rsclear       <= 1'b0;
            ctl.rsshr         <= 1'b0;
            ctl.mrld          <= 1'b0;
            ctl.mdld          <= 1'b0;
            ctl.busy_t        <= 1'b0;
            ctl.productDone_t <= 1'b0;
            ctl.rsload_t      <= 1'b0;
            ctl.rsclear_t     <= 1'b0;
            ctl.rsshr_t       <= 1'b0;
            ctl.mrld_t        <= 1'b0;
            ctl.mdld_t        <= 1'b0;
        end else begin
            state             <= state_nx;
            bit_cnt           <= bit_cnt_nx;
            time_t            <= time_t_nx;
            sel_t             <= sel_t_nx;
            cnt_t             <= cnt_t_nx;
            ctl.busy          <= (state_nx != IDLE);
            ctl.productDone   <= (state_nx == DONE);
            ctl.rsload        <= (state_nx == LOAD);
            ctl.rsclear       <= (state_nx == INIT);
            ctl.rsshr         <= (state_nx == SHIFT);
            ctl.mrld          <= (state_nx == INIT);
            ctl.mdld          <= (state_nx == INIT);
            ctl.busy_t        <= time_t_nx;
            ctl.productDone_t <= time_t_nx;
            ctl.rsload_t      <= time_t_nx | sel_t_nx;
            ctl.rsclear_t     <= time_t_nx;
            ctl.rsshr_t       <= time_t_nx;
            ctl.mrld_t        <= time_t_nx;
            ctl.mdld_t        <= time_t_nx;
        end
    end
endmodule

// File: tb/tb_multiplier_control_taint_v2.sv
// Self-checking bench for multiplier_control_taint_v2. A schedule-based
// model predicts the output phase of every cycle of a run; a compare
// process checks all outputs every cycle, and directed tests pin latency,
// pulse counts and taint behaviour with hand-computed literals.
module tb_multiplier_control_taint_v2;
    localparam int W = 4;

`ifdef MULT_ZERO_SKIP_EN
    localparam bit ZS       = 1'b1;
    localparam int LAT_1011 = 9;    // 4 + popcount 3 + 2
    localparam int LAT_1000 = 7;    // 4 + 1 + 2
`else
    localparam bit ZS       = 1'b0;
    localparam int LAT_1011 = 10;   // 2*4 + 2
    localparam int LAT_1000 = 10;
`endif
    localparam int LAT_1111 = 10;   // same in both modes

    localparam int P_IDLE = 0, P_INIT = 1, P_LOAD = 2, P_NOP = 3, P_SHIFT = 4, P_DONE = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiplier_control_taint_v2_if #(.WIDTH(W)) ifc ();

    multiplier_control_taint_v2 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (ifc.slave)
    );

    logic [13:0] outs;
    assign outs = {ifc.busy, ifc.busy_t, ifc.productDone, ifc.productDone_t,
                   ifc.rsload, ifc.rsload_t, ifc.rsclear, ifc.rsclear_t,
                   ifc.rsshr, ifc.rsshr_t, ifc.mrld, ifc.mrld_t,
                   ifc.mdld, ifc.mdld_t};

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int cur = P_IDLE;
    int sched[$];
    bit m_time = 0, m_sel = 0, m_cnt = 0;
    bit m_valid = 0;
    int cyc = 0;
    int acc_edge = 0;

    task automatic build_sched(input logic [W-1:0] mr);
        sched.delete();
        sched.push_back(P_INIT);
        for (int i = 0; i < W; i++) begin
            if (mr[i]) sched.push_back(P_LOAD);
            else if (!ZS) sched.push_back(P_NOP);
            sched.push_back(P_SHIFT);
        end
        sched.push_back(P_DONE);
    endtask

    function automatic logic [13:0] exp_outs(input int ph, input bit t, input bit s);
        return {ph != P_IDLE, t, ph == P_DONE, t, ph == P_LOAD, t | s,
                ph == P_INIT, t, ph == P_SHIFT, t, ph == P_INIT, t,
                ph == P_INIT, t};
    endfunction

    always @(posedge clk) begin
        bit in_idle, dec, dt, clr, nt, ns, nc;
        cyc = cyc + 1;
        if (rst) begin
            sched.delete();
            cur = P_IDLE;
            m_time = 0; m_sel = 0; m_cnt = 0;
            m_valid = 1;
        end else begin
            in_idle = (cur == P_IDLE);
            dec     = (cur == P_INIT) || (cur == P_SHIFT);
            dt      = ifc.multiplierReg_t || m_cnt;
            clr     = in_idle && ifc.taint_clr;
            nt = (m_time && !clr) || (in_idle && ifc.start_t) || (ZS && dec && dt);
            ns = (m_sel && !clr) || (dec && dt);
            nc = (m_cnt && !clr) || (dec && m_time);
            m_time = nt; m_sel = ns; m_cnt = nc;
            if (in_idle && ifc.start) begin
                build_sched(ifc.multiplierReg);
                acc_edge = cyc;
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = P_IDLE;
        end
    end

    // ---------------- compare / monitor ----------------
    int done_off   = -1;
    bit done_t     = 0;
    int rsload_cnt = 0;
    int mdld_cnt   = 0;
    int last_mdld  = 0;
    int prev_mdld  = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            check("outputs_vs_model", 32'(outs), 32'(exp_outs(cur, m_time, m_sel)));
            if (ifc.productDone === 1'b1) begin
                done_off = cyc + 1 - acc_edge;
                done_t   = ifc.productDone_t;
            end
            if (ifc.rsload === 1'b1) rsload_cnt++;
            if (ifc.mdld === 1'b1) begin
                mdld_cnt++;
                prev_mdld = last_mdld;
                last_mdld = cyc + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic kick(input bit st_t);
        done_off   = -1;
        rsload_cnt = 0;
        ifc.start   = 1'b1;
        ifc.start_t = st_t;
        step();
        ifc.start   = 1'b0;
        ifc.start_t = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_off < 0 && n < 50) begin
            step();
            n++;
        end
        if (done_off < 0) check("done_timeout", 32'd0, 32'd1);
        step();  // DONE -> IDLE
    endtask

    task automatic clear_taints();
        ifc.taint_clr = 1'b1;
        step();
        ifc.taint_clr = 1'b0;
    endtask

    initial begin
        ifc.start           = 1'b0;
        ifc.start_t         = 1'b0;
        ifc.taint_clr       = 1'b0;
        ifc.multiplierReg   = '0;
        ifc.multiplierReg_t = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_outputs_zero", 32'(outs), 32'd0);

        // 1: plain run, 1011
        ifc.multiplierReg = 4'b1011;
        kick(1'b0);
        wait_done();
        check("t1_latency", done_off, LAT_1011);
        check("t1_rsload_pulses", rsload_cnt, 3);
        check("t1_idle_outputs", 32'(outs), 32'd0);

        // boundary: only MSB set
        ifc.multiplierReg = 4'b1000;
        kick(1'b0);
        wait_done();
        check("msb_latency", done_off, LAT_1000);
        check("msb_rsload_pulses", rsload_cnt, 1);

        // 2: multiplier word tainted
        ifc.multiplierReg   = 4'b1011;
        ifc.multiplierReg_t = 1'b1;
        kick(1'b0);
        wait_done();
        ifc.multiplierReg_t = 1'b0;
        check("t2_rsload_t", ifc.rsload_t, 1);
        check("t2_productDone_t", done_t, ZS);
        check("t2_rsshr_t", ifc.rsshr_t, ZS);
        clear_taints();
        check("t2_cleared", 32'(outs), 32'd0);

        // 3: tainted start; clear while busy has no effect
        kick(1'b1);
        ifc.taint_clr = 1'b1;
        step();
        ifc.taint_clr = 1'b0;
        check("t3_busy_t_mid", ifc.busy_t, 1);
        wait_done();
        check("t3_productDone_t", done_t, 1);
        check("t3_taints_after_done", 32'(outs), 32'h155F & 32'h1555 | 32'h0400);
        clear_taints();
        check("t3_cleared", 32'(outs), 32'd0);
        ifc.taint_clr = 1'b1;
        ifc.start_t   = 1'b1;
        step();
        ifc.taint_clr = 1'b0;
        ifc.start_t   = 1'b0;
        check("t3_set_wins", ifc.busy_t, 1);
        clear_taints();
        check("t3_cleared_again", 32'(outs), 32'd0);

        // 4: reset during a SHIFT cycle, then a clean restart
        ifc.multiplierReg = 4'b1011;
        kick(1'b0);
        step();
        step();
        check("t4_in_shift", ifc.rsshr, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_reset_outputs", 32'(outs), 32'd0);
        kick(1'b0);
        wait_done();
        check("t4_restart_latency", done_off, LAT_1011);

        // 5: start held high across a full run
        ifc.multiplierReg = 4'b1111;
        mdld_cnt  = 0;
        ifc.start = 1'b1;
        repeat (12) step();
        ifc.start = 1'b0;
        done_off  = -1;
        wait_done();
        check("t5_run_count", mdld_cnt, 2);
        check("t5_init_spacing", last_mdld - prev_mdld, 11);
        check("t5_latency", done_off, LAT_1111);

`ifdef MULT_ZERO_SKIP_EN
        // 6: zero skip with a single low bit set, tainted word
        ifc.multiplierReg   = 4'b0001;
        ifc.multiplierReg_t = 1'b1;
        kick(1'b0);
        wait_done();
        ifc.multiplierReg_t = 1'b0;
        check("t6_latency", done_off, 7);
        check("t6_productDone_t", done_t, 1);
        clear_taints();
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
